crc_frame_ctrl: RTL

Sequencer for the bit-serial CRC engine (N-bit LFSR with Data/Active/Valid/CRC serial I/O). Accepts a frame of N-bit bytes over a valid/ready stream and clears the engine before each frame. Serializes each byte LSB-first into the engine with Active held high, then drains the N-bit serial CRC into a parallel result register. Presents that result on a valid/ready output. Sits between the packet front-end and the engine and is the engine's sole driver.

---
 rtl/crc_frame_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: sequencer for the bit-serial CRC engine.
// Takes a frame of N-bit bytes over valid/ready, clears the engine, streams
// each byte LSB-first with Eng_Active high, drains the serial CRC into
// Crc_Out and offers it on a valid/ready output.
module crc_frame_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned LEN_W    = 5,
  parameter int unsigned DRAIN_TO = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [N-1:0] In_Data,
  input  logic         In_Valid,
  input  logic         In_Last,
  output logic         In_Ready,
  output logic         Eng_Rst,
  output logic         Eng_Data,
  output logic         Eng_Active,
  input  logic         Eng_Valid,
  input  logic         Eng_CRC,
  output logic [N-1:0] Crc_Out,
  output logic         Crc_Valid,
  input  logic         Crc_Ready,
  output logic         Busy,
  output logic         Err
);

  localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TO_W  = $clog2(DRAIN_TO + 1);

  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(N - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(DRAIN_TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    HOLD,
    ABORT
  } state_t;

  state_t           state;
  logic [N-1:0]     sreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] drain_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             last_flag;
  logic             bit_last;
  logic             in_acc;

  // In_Ready opens in IDLE and on the final bit of a non-last byte only
  always_comb begin
    bit_last = (bit_cnt == BIT_MAX);
    In_Ready = 1'b0;
    if (Rst) begin
      case (state)
        IDLE:    In_Ready = 1'b1;
        SHIFT:   In_Ready = bit_last && !last_flag;
        default: In_Ready = 1'b0;
      endcase
    end
    in_acc = In_Valid && In_Ready;
  end

  // Frame sequencer with registered engine and result outputs.
  // Eng_Data is registered: the edge ending bit k loads bit k+1, the CLR edge
  // preloads bit 0, and a mid-frame accept loads the new byte's bit 0 directly
  // so the stream to the engine has no gap between bytes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      drain_cnt  <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      last_flag  <= 1'b0;
      Eng_Rst    <= 1'b0;
      Eng_Data   <= 1'b0;
      Eng_Active <= 1'b0;
      Crc_Out    <= '0;
      Crc_Valid  <= 1'b0;
      Busy       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Eng_Rst <= 1'b1;
      Err     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_acc) begin
            sreg      <= In_Data;
            byte_cnt  <= LEN_W'(1);
            last_flag <= In_Last;
            Eng_Rst   <= 1'b0;
            Busy      <= 1'b1;
            state     <= CLR;
          end
        end
        CLR: begin
          Eng_Active <= 1'b1;
          Eng_Data   <= sreg[0];
          sreg       <= sreg >> 1;
          bit_cnt    <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (!bit_last) begin
            Eng_Data <= sreg[0];
            sreg     <= sreg >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
          end else if (last_flag) begin
            Eng_Active <= 1'b0;
            Eng_Data   <= 1'b0;
            drain_cnt  <= '0;
            to_cnt     <= '0;
            state      <= DRAIN;
          end else if (in_acc && (byte_cnt != LEN_MAX)) begin
            Eng_Data  <= In_Data[0];
            sreg      <= In_Data >> 1;
            bit_cnt   <= '0;
            byte_cnt  <= byte_cnt + 1'b1;
            last_flag <= In_Last;
          end else begin
            // Missing byte, or one byte too many without In_Last
            Eng_Active <= 1'b0;
            Eng_Data   <= 1'b0;
            Eng_Rst    <= 1'b0;
            Err        <= 1'b1;
            state      <= ABORT;
          end
        end
        DRAIN: begin
          if (Eng_Valid) begin
            Crc_Out[drain_cnt] <= Eng_CRC;
            drain_cnt          <= drain_cnt + 1'b1;
            to_cnt             <= '0;
            if (drain_cnt == BIT_MAX) begin
              Crc_Valid <= 1'b1;
              state     <= HOLD;
            end
          end else if (to_cnt == TO_MAX) begin
            Eng_Rst <= 1'b0;
            Err     <= 1'b1;
            state   <= ABORT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (Crc_Ready) begin
            Crc_Valid <= 1'b0;
            Busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        ABORT: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
